// File: rtl/snn_mem_pkg.sv
// Shared definitions for the spike pattern/record memories.
package snn_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } rec_state_e;

    localparam rec_state_e RST_STATE    = ST_IDLE;
    localparam logic       RST_OVERFLOW = 1'b0;
    localparam logic       RST_RD_VALID = 1'b0;

    // Number of host-sized batches needed to cover one spike vector.
    function automatic int num_batches(input int num_spikes, input int spikes_per_batch);
        return (num_spikes + spikes_per_batch - 1) / spikes_per_batch;
    endfunction

endpackage

// File: rtl/spike_record_ram.sv
// Simple dual-port RAM: synchronous full-width write, registered full-width read.
module spike_record_ram #(
    parameter int AW = 8,
    parameter int DW = 100
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_word
);

    // Contents are never reset; zero start value only matters in simulation.
    logic [DW-1:0] mem_q [2**AW] = '{default: '0};
    logic [DW-1:0] rd_word_q;

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read register; a same-address write in this cycle is not visible yet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_word_q <= '0;
        end else if (rd_en) begin
            rd_word_q <= mem_q[rd_addr];
        end
    end

    assign rd_word = rd_word_q;

endmodule

// File: rtl/spike_record_mem.sv
// Captures one output spike vector per timestep and serves host batch reads.
module spike_record_mem
    import snn_mem_pkg::*;
#(
    parameter int NUM_SPIKES                     = 100,
    parameter int TIMESTEP_ADDR_WIDTH            = 8,
    parameter int SPIKE_PATTERN_BATCH_ADDR_WIDTH = 6,
    parameter int SPIKES_PER_BATCH               = 32
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic [TIMESTEP_ADDR_WIDTH-1:0]            last_timestep,
    input  logic [NUM_SPIKES-1:0]                     spikes_in,
    input  logic                                      spikes_valid,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      overflow,
    output logic [TIMESTEP_ADDR_WIDTH:0]              capture_count,
    input  logic                                      rd_en,
    input  logic [TIMESTEP_ADDR_WIDTH-1:0]            rd_addr,
    input  logic [SPIKE_PATTERN_BATCH_ADDR_WIDTH-1:0] batch_sel,
    output logic [SPIKES_PER_BATCH-1:0]               rd_data,
    output logic                                      rd_valid
);

    localparam int AW    = TIMESTEP_ADDR_WIDTH;
    localparam int CW    = TIMESTEP_ADDR_WIDTH + 1;
    localparam int NB    = num_batches(NUM_SPIKES, SPIKES_PER_BATCH);
    localparam int PW    = NB * SPIKES_PER_BATCH;

    rec_state_e     state_q, state_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  last_q, last_d;
    logic [CW-1:0]  count_q, count_d;
    logic           ovf_q, ovf_d;
    logic           wr_en;
    logic                                      rd_valid_q;
    logic [SPIKE_PATTERN_BATCH_ADDR_WIDTH-1:0] bsel_q;
    logic [NUM_SPIKES-1:0]                     ram_word;
    logic [PW-1:0]                             padded;

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RST_STATE;
            wr_ptr_q <= '0;
            last_q   <= '0;
            count_q  <= '0;
            ovf_q    <= RST_OVERFLOW;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            last_q   <= last_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Next-state, write strobe and run bookkeeping.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        last_d   = last_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        wr_en    = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_CAPTURE;
                    wr_ptr_d = '0;
                    count_d  = '0;
                    ovf_d    = 1'b0;
                    last_d   = last_timestep;
                end else if (state_q == ST_DONE && spikes_valid) begin
                    ovf_d = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (spikes_valid) begin
                    wr_en   = 1'b1;
                    count_d = count_q + CW'(1);
                    if (wr_ptr_q == last_q) begin
                        state_d = ST_DONE;
                    end else begin
                        wr_ptr_d = wr_ptr_q + AW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy          = (state_q == ST_CAPTURE);
    assign done          = (state_q == ST_DONE);
    assign overflow      = ovf_q;
    assign capture_count = count_q;

    spike_record_ram #(
        .AW (AW),
        .DW (NUM_SPIKES)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (spikes_in),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_word (ram_word)
    );

    // Batch select travels alongside the RAM read register so rd_data holds between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= RST_RD_VALID;
            bsel_q     <= '0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                bsel_q <= batch_sel;
            end
        end
    end

    assign padded   = PW'(ram_word);
    assign rd_valid = rd_valid_q;

    // Batch mux; padding above NUM_SPIKES and out-of-range batches read as zero.
    always_comb begin
        rd_data = '0;
        if (int'(bsel_q) < NB) begin
            rd_data = padded[int'(bsel_q)*SPIKES_PER_BATCH +: SPIKES_PER_BATCH];
        end
    end

endmodule

// File: doc/spike_record_mem.md
# spike_record_mem

Output-side counterpart of the spike pattern memory. It captures the network's output spike vector once per timestep during a run, storing one full-width word per timestep. After the run, the host reads the stored vectors back in SPIKES_PER_BATCH-bit batches, using the same timestep-address plus batch-select scheme the host uses to load input patterns.

## Interface
- NUM_SPIKES, 100, width of captured spike vector (output neurons)
- TIMESTEP_ADDR_WIDTH, 8, timestep address width; depth = 2**TIMESTEP_ADDR_WIDTH
- SPIKE_PATTERN_BATCH_ADDR_WIDTH, 6, batch select width
- SPIKES_PER_BATCH, 32, host read word width
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  pulse; arms a capture run
- last_timestep  input  TIMESTEP_ADDR_WIDTH  index of final timestep to capture; sampled on accepted start
- spikes_in  input  NUM_SPIKES  output spike vector for current timestep
- spikes_valid  input  1  spikes_in is valid this cycle (one pulse per timestep)
- busy  output  1  high in CAPTURE
- done  output  1  high in DONE
- overflow  output  1  sticky: spikes_valid seen in DONE
- capture_count  output  TIMESTEP_ADDR_WIDTH+1  timesteps written this run
- rd_en  input  1  host read request
- rd_addr  input  TIMESTEP_ADDR_WIDTH  timestep to read
- batch_sel  input  SPIKE_PATTERN_BATCH_ADDR_WIDTH  batch within timestep
- rd_data  output  SPIKES_PER_BATCH  read result
- rd_valid  output  1  rd_data valid

## Operation
- States: IDLE, CAPTURE, DONE.
- IDLE:
  - start → CAPTURE; wr_ptr=0, capture_count=0, overflow=0; latch last_timestep.
  - spikes_valid is ignored.
- CAPTURE:
  - Each spikes_valid writes spikes_in to mem[wr_ptr]; wr_ptr and capture_count increment.
  - A write with wr_ptr==last_timestep → DONE. wr_ptr is not incremented past it, so there is no wrap.
  - start is ignored.
- DONE:
  - start → CAPTURE, with the same initialisation as from IDLE.
  - spikes_valid sets overflow and writes nothing.
  - start and spikes_valid in the same cycle: start wins; the spike is not captured and overflow is not set.
- last_timestep=0: one write, then DONE. last_timestep=2**TIMESTEP_ADDR_WIDTH-1: the whole memory is filled and capture_count reaches 2**TIMESTEP_ADDR_WIDTH.
- Host read:
  - rd_data = bits [batch_sel*SPIKES_PER_BATCH +: SPIKES_PER_BATCH] of mem[rd_addr]; bit k of rd_data is spike batch_sel*SPIKES_PER_BATCH+k.
  - Bits at or above NUM_SPIKES read as 0.
  - A batch_sel entirely beyond NUM_SPIKES returns 0.
- Reads are legal in any state. A read of the address being written in the same cycle returns the old contents (read-before-write).
- Memory contents are not reset; they are initialised to 0 at time zero for simulation. rst does not clear captured data.

## Timing
- Reset values: state IDLE, busy 0, done 0, overflow 0, capture_count 0, rd_data 0, rd_valid 0, wr_ptr 0.
- busy/done are registered state decodes:
  - busy rises the cycle after start.
  - done rises the cycle after the final write.
- Write: spikes_valid at edge N stores at edge N; the data is readable by a read issued at edge N+1 or later.
- Read latency is 1 cycle. rd_en at edge N gives rd_data/rd_valid after edge N; rd_valid is high for exactly one cycle per rd_en.
- When rd_valid=0, rd_data holds its last value.
- Back-to-back rd_en every cycle is supported at full throughput.
- rst mid-CAPTURE returns immediately to IDLE with all outputs at reset values. Partially written data remains in memory.

## Structure
- Shared package snn_mem_pkg holds:
  - the state enum (IDLE, CAPTURE, DONE);
  - a function returning the number of batches, ceil(NUM_SPIKES/SPIKES_PER_BATCH);
  - the reset-value constants.
- The spike pattern memory uses the same package for its batch count.
- Sub-module spike_record_ram: simple dual-port RAM, 2**TIMESTEP_ADDR_WIDTH × NUM_SPIKES.
  - Write port: full-width, synchronous.
  - Read port: registered full-width word.
  - The batch mux and zero-fill live in spike_record_mem, after the RAM read register.

## Test plan
- Reset, then rst deasserted: all outputs 0. rd_en at addr 0 → rd_valid next cycle, rd_data=0.
- start with last_timestep=3, then 4 spikes_valid pulses of vectors with bit t*10 set at timestep t → done after 4th write, capture_count=4. rd_addr=2, batch_sel=0 → rd_data=0x00100000.
- Capture with bit 99 set, read batch_sel=3 → rd_data=0x00000008. Read batch_sel=4 and batch_sel=63 → 0.
- In DONE, an extra spikes_valid → overflow=1 and memory unchanged. A later start → overflow=0, busy=1.
- rst asserted after 2 of 5 writes → IDLE, busy=0, capture_count=0. Reading addr 1 still returns the data written before reset.
- Run with last_timestep=255 → capture_count=256 and done. rd_addr=255 returns the final vector. A same-cycle read/write to one address returns the old value.
